// File: rtl/systolic_array_ctrl.sv
// Job sequencer for the 3x3 systolic array: loads A|B beats from s_axis into the
// operand buffers, replays them into the array, drains the pipeline and hands the result to m_axis.
module systolic_array_ctrl #(
  parameter int K_DEPTH      = 3,
  parameter int DRAIN_CYCLES = 5,
  parameter int CNT_W        = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic s_axis_valid,
  output logic s_axis_ready,
  output logic buff_wr,
  output logic buff_rd,
  input  logic buff_full_a,
  input  logic buff_full_b,
  input  logic buff_empty_a,
  input  logic buff_empty_b,
  output logic array_clr,
  output logic array_en,
  output logic array_zero,
  output logic res_capture,
  output logic m_axis_valid,
  input  logic m_axis_ready,
  output logic o_busy
);

  typedef enum logic [2:0] {
    S_CLEAR,
    S_LOAD,
    S_FEED,
    S_DRAIN,
    S_OUT
  } state_t;

  localparam logic [CNT_W-1:0] K_LAST  = CNT_W'(K_DEPTH - 1);
  localparam logic [CNT_W-1:0] DR_LAST = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           r_state;
  logic [CNT_W-1:0] r_beat_cnt;
  logic [CNT_W-1:0] r_rd_cnt;
  logic [CNT_W-1:0] r_dr_cnt;
  logic             r_feed_valid;

  logic w_load;
  logic w_feed;
  logic w_drain;

  assign w_load  = (r_state == S_LOAD);
  assign w_feed  = (r_state == S_FEED);
  assign w_drain = (r_state == S_DRAIN);

  // Handshakes stay combinational so a freed buffer slot or a refilled buffer is used the same cycle.
  assign s_axis_ready = w_load & ~buff_full_a & ~buff_full_b;
  assign buff_wr      = s_axis_valid & s_axis_ready;
  assign buff_rd      = w_feed & ~buff_empty_a & ~buff_empty_b;

  // Buffer read data lands one cycle after buff_rd, so the array steps on the delayed strobe.
  assign array_en     = r_feed_valid | w_drain;
  assign array_zero   = w_drain & ~r_feed_valid;
  assign array_clr    = (r_state == S_CLEAR);
  assign res_capture  = w_drain & (r_dr_cnt == DR_LAST);
  assign m_axis_valid = (r_state == S_OUT);
  assign o_busy       = ~(w_load & (r_beat_cnt == '0));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_CLEAR;
      r_beat_cnt   <= '0;
      r_rd_cnt     <= '0;
      r_dr_cnt     <= '0;
      r_feed_valid <= 1'b0;
    end else begin
      r_feed_valid <= buff_rd;
      case (r_state)
        S_CLEAR: begin
          r_beat_cnt <= '0;
          r_rd_cnt   <= '0;
          r_dr_cnt   <= '0;
          r_state    <= S_LOAD;
        end
        S_LOAD: begin
          if (buff_wr) begin
            if (r_beat_cnt == K_LAST) begin
              r_beat_cnt <= '0;
              r_state    <= S_FEED;
            end else begin
              r_beat_cnt <= r_beat_cnt + CNT_ONE;
            end
          end
        end
        S_FEED: begin
          if (buff_rd) begin
            if (r_rd_cnt == K_LAST) begin
              r_rd_cnt <= '0;
              r_state  <= S_DRAIN;
            end else begin
              r_rd_cnt <= r_rd_cnt + CNT_ONE;
            end
          end
        end
        S_DRAIN: begin
          if (r_dr_cnt == DR_LAST) begin
            r_dr_cnt <= '0;
            r_state  <= S_OUT;
          end else begin
            r_dr_cnt <= r_dr_cnt + CNT_ONE;
          end
        end
        S_OUT: begin
          if (m_axis_ready) r_state <= S_CLEAR;
        end
        default: r_state <= S_CLEAR;
      endcase
    end
  end

endmodule
